// File: rtl/baudgen_frac.sv
// Fractional baud generator: oversample tick, per-bit baud edge and mid-bit strobe.
// Optional fractional divisor enabled by defining BAUDGEN_FRAC_EN.
module baudgen_frac #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              baud_edge,
  output logic              mid_bit
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre_cnt;
  logic [DIV_W-1:0] last_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             term;

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] acc;
  logic              ext_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
`else
  logic frac_unused;

  assign frac_unused = ^div_frac;
`endif

  // div_q of 0 behaves as 1; last_cnt never overflows since max(div_q,1)-1+1 fits.
  always_comb begin
    last_cnt = (div_q == '0) ? '0 : div_q - 1'b1;
`ifdef BAUDGEN_FRAC_EN
    last_cnt = last_cnt + DIV_W'(ext_q);
`endif
    term = (pre_cnt == last_cnt);
  end

  always_ff @(posedge clk) begin
    os_tick   <= 1'b0;
    baud_edge <= 1'b0;
    mid_bit   <= 1'b0;
    if (!rst_n) begin
      div_q   <= DIV_W'(DEFAULT_DIV);
      pre_cnt <= '0;
      os_cnt  <= '0;
`ifdef BAUDGEN_FRAC_EN
      frac_q  <= '0;
      acc     <= '0;
      ext_q   <= 1'b0;
`endif
    end else if (div_load || resync) begin
      if (div_load) begin
        div_q  <= div_int;
`ifdef BAUDGEN_FRAC_EN
        frac_q <= div_frac;
`endif
      end
      pre_cnt <= '0;
      os_cnt  <= '0;
`ifdef BAUDGEN_FRAC_EN
      acc     <= '0;
      ext_q   <= 1'b0;
`endif
    end else if (en) begin
      if (!term) begin
        pre_cnt <= pre_cnt + 1'b1;
      end else begin
        pre_cnt <= '0;
        os_tick <= 1'b1;
`ifdef BAUDGEN_FRAC_EN
        // Carry out of the accumulator stretches the next period by one cycle.
        acc     <= acc_sum[FRAC_W-1:0];
        ext_q   <= acc_sum[FRAC_W];
`endif
        if (os_cnt == OS_LAST) begin
          os_cnt    <= '0;
          baud_edge <= 1'b1;
        end else begin
          os_cnt <= os_cnt + OS_W'(1);
        end
        if (os_cnt == OS_MID) mid_bit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baudgen_frac.sv
// Directed bench for baudgen_frac; expected fractional timing depends on BAUDGEN_FRAC_EN.
module tb_baudgen_frac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick, baud_edge, mid_bit;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  baudgen_frac #(.DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEFAULT_DIV(13)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .resync(resync), .os_tick(os_tick), .baud_edge(baud_edge),
    .mid_bit(mid_bit)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input int f);
    div_int  = 16'(d);
    div_frac = 4'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    int first_tick = -1, first_mid = -1, first_baud = -1, nt = 0, bad = 0, zb = 0;
    en = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      step();
      if (os_tick || mid_bit || baud_edge) zb++;
    end
    tests++;
    if (zb !== 0) begin fails++; $display("FAIL reset_outputs: got %0d nonzero cycles, want 0", zb); end
    rst_n = 1'b1;
    for (int c = 1; c <= 210; c++) begin
      step();
      if (os_tick) begin
        nt++;
        if (first_tick < 0) first_tick = c;
        if (c % 13 != 0) bad++;
      end
      if (mid_bit && first_mid < 0) first_mid = c;
      if (baud_edge && first_baud < 0) first_baud = c;
      if (((baud_edge || mid_bit) && !os_tick) || (baud_edge && mid_bit)) bad++;
    end
    tests++;
    if (first_tick !== 13) begin fails++; $display("FAIL reset_first_tick: got %0d, want 13", first_tick); end
    tests++;
    if (first_mid !== 104) begin fails++; $display("FAIL reset_first_mid: got %0d, want 104", first_mid); end
    tests++;
    if (first_baud !== 208) begin fails++; $display("FAIL reset_first_baud: got %0d, want 208", first_baud); end
    tests++;
    if (nt !== 16 || bad !== 0) begin fails++; $display("FAIL reset_tick_grid: got %0d ticks %0d bad, want 16 ticks 0 bad", nt, bad); end
  endtask

  task automatic test_frac();
    int q[$];
    int first_baud = -1, bad = 0, exp_gap, gap, exp_baud;
    load(8, 8);
    for (int c = 1; c <= 140; c++) begin
      step();
      if (os_tick) q.push_back(c);
      if (baud_edge && first_baud < 0) first_baud = c;
    end
`ifdef BAUDGEN_FRAC_EN
    // Carries come from ticks 2,4,..., so periods run 8,8,9,8,9,...: 135 for 16 ticks.
    exp_baud = 135;
`else
    exp_baud = 128;
`endif
    if (q.size() < 16) bad = 100;
    else begin
      for (int k = 0; k < 16; k++) begin
`ifdef BAUDGEN_FRAC_EN
        exp_gap = (k >= 2 && k % 2 == 0) ? 9 : 8;
`else
        exp_gap = 8;
`endif
        gap = q[k] - ((k == 0) ? 0 : q[k-1]);
        if (gap != exp_gap) bad++;
      end
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL frac_periods: got %0d bad gaps (%0d ticks), want 0", bad, q.size()); end
    tests++;
    if (first_baud !== exp_baud) begin fails++; $display("FAIL frac_baud: got %0d, want %0d", first_baud, exp_baud); end
  endtask

  task automatic test_resync();
    int nt = 0, guard = 0, first_tick = -1, first_mid = -1, zb = 0;
    load(4, 0);
    while (nt < 5 && guard < 100) begin
      step();
      guard++;
      if (os_tick) nt++;
    end
    tests++;
    if (nt !== 5) begin fails++; $display("FAIL resync_wait: got %0d ticks, want 5", nt); end
    resync = 1'b1;
    step();
    resync = 1'b0;
    if (os_tick || mid_bit || baud_edge) zb++;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (os_tick && first_tick < 0) first_tick = c;
      if (mid_bit && first_mid < 0) first_mid = c;
    end
    tests++;
    if (first_tick !== 4 || zb !== 0) begin fails++; $display("FAIL resync_tick: got %0d (zero-check %0d), want 4 (0)", first_tick, zb); end
    tests++;
    if (first_mid !== 32) begin fails++; $display("FAIL resync_mid: got %0d, want 32", first_mid); end
  endtask

  task automatic test_enable();
    int guard = 0, pulses = 0, n = -1;
    load(4, 0);
    while (!os_tick && guard < 20) begin step(); guard++; end
    step();
    step();
    en = 1'b0;
    repeat (10) begin
      step();
      if (os_tick || mid_bit || baud_edge) pulses++;
    end
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (os_tick && n < 0) n = c;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL en_hold_pulses: got %0d, want 0", pulses); end
    tests++;
    if (n !== 2) begin fails++; $display("FAIL en_resume: got %0d, want 2", n); end
  endtask

  task automatic test_reset_mid();
    int first_tick = -1, first_mid = -1, nt = 0, zb = 0;
    load(20, 0);
    repeat (50) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if (os_tick || mid_bit || baud_edge) zb++;
    for (int c = 1; c <= 110; c++) begin
      step();
      if (os_tick) begin nt++; if (first_tick < 0) first_tick = c; end
      if (mid_bit && first_mid < 0) first_mid = c;
    end
    tests++;
    if (first_tick !== 13 || nt !== 8 || zb !== 0) begin
      fails++; $display("FAIL rst_mid_div: got first %0d count %0d zero-check %0d, want 13 8 0", first_tick, nt, zb);
    end
    tests++;
    if (first_mid !== 104) begin fails++; $display("FAIL rst_mid_oscnt: got %0d, want 104", first_mid); end
  endtask

  task automatic test_div_small();
    for (int d = 0; d <= 1; d++) begin
      int miss = 0, nb = 0, first_baud = -1, first_mid = -1;
      load(d, 0);
      for (int c = 1; c <= 40; c++) begin
        step();
        if (!os_tick) miss++;
        if (baud_edge) begin nb++; if (first_baud < 0) first_baud = c; end
        if (mid_bit && first_mid < 0) first_mid = c;
      end
      tests++;
      if (miss !== 0) begin fails++; $display("FAIL div%0d_tick_every_cycle: got %0d missing, want 0", d, miss); end
      tests++;
      if (nb !== 2 || first_baud !== 16 || first_mid !== 8) begin
        fails++; $display("FAIL div%0d_baud: got %0d edges first %0d mid %0d, want 2 16 8", d, nb, first_baud, first_mid);
      end
    end
  endtask

  task automatic test_load_resync();
    int first_tick = -1, second = -1;
    div_int = 16'd5;
    div_load = 1'b1;
    resync = 1'b1;
    step();
    div_load = 1'b0;
    resync = 1'b0;
    div_int = 16'd3;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (os_tick) begin
        if (first_tick < 0) first_tick = c;
        else if (second < 0) second = c;
      end
    end
    tests++;
    if (first_tick !== 5) begin fails++; $display("FAIL load_resync_tick: got %0d, want 5", first_tick); end
    tests++;
    if (second !== 10) begin fails++; $display("FAIL no_load_change: got %0d, want 10", second); end
  endtask

  initial begin
    test_reset();
    test_frac();
    test_resync();
    test_enable();
    test_reset_mid();
    test_div_small();
    test_load_resync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
